// File: rtl/seq_recognizer_param.sv
// Serial pattern recognizer with a runtime-loaded pattern of up to MAX_LEN bits,
// overlapping or non-overlapping detection, and a saturating match counter.
module seq_recognizer_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           x,
  input  logic                           en,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           count_clr,
  output logic                           z,
  output logic [CNT_W-1:0]               match_count,
  output logic                           armed
);

  localparam int LW = $clog2(MAX_LEN+1);
  localparam logic [LW-1:0]    LenMax = LW'(MAX_LEN);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [MAX_LEN-1:0] histQ, histD, histShift, lenMask, patQ, patD;
  logic [LW-1:0]      fillQ, fillD, fillInc, lenQ, lenD, cfgLenClamped;
  logic               ovlQ, ovlD, zQ, zD, match;
  logic [CNT_W-1:0]   cntQ, cntD;

  // Candidate history after a sample, and the match it would produce.
  always_comb begin
    histShift = {histQ[MAX_LEN-2:0], x};
    fillInc   = (fillQ == LenMax) ? fillQ : fillQ + LW'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      lenMask[i] = (i < int'(lenQ));
    end
    match = en && !cfg_load && (fillInc >= lenQ) &&
            (((histShift ^ patQ) & lenMask) == '0);
  end

  // A zero length makes no sense as a pattern, so it is treated as one bit.
  always_comb begin
    if (cfg_len == '0) begin
      cfgLenClamped = LW'(1);
    end else if (cfg_len > LenMax) begin
      cfgLenClamped = LenMax;
    end else begin
      cfgLenClamped = cfg_len;
    end
  end

  always_comb begin
    histD = histQ;
    fillD = fillQ;
    patD  = patQ;
    lenD  = lenQ;
    ovlD  = ovlQ;
    zD    = match;
    if (cfg_load) begin
      patD  = cfg_pattern;
      lenD  = cfgLenClamped;
      ovlD  = cfg_overlap;
      histD = '0;
      fillD = '0;
    end else if (en) begin
      histD = histShift;
      fillD = (match && !ovlQ) ? '0 : fillInc;
    end
  end

  // Counter clear still credits a match landing on the same edge.
  always_comb begin
    cntD = cntQ;
    if (match && (cntQ != CntMax)) begin
      cntD = cntQ + CNT_W'(1);
    end
    if (count_clr) begin
      cntD = match ? CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      histQ <= '0;
      fillQ <= '0;
      patQ  <= '0;
      lenQ  <= LenMax;
      ovlQ  <= 1'b1;
      zQ    <= 1'b0;
      cntQ  <= '0;
    end else begin
      histQ <= histD;
      fillQ <= fillD;
      patQ  <= patD;
      lenQ  <= lenD;
      ovlQ  <= ovlD;
      zQ    <= zD;
      cntQ  <= cntD;
    end
  end

  assign z           = zQ;
  assign match_count = cntQ;
  assign armed       = (fillQ >= lenQ);

endmodule

// File: tb/tb_seq_recognizer_param.sv
// Self-checking bench: a queue-based model of the sampled bit stream is checked
// against two DUT instances (8-bit and 2-bit counters) every cycle.
module tb_seq_recognizer_param;

  localparam int MAX_LEN = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0, en = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0, count_clr = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       z, z2, armed, armed2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int nVec  = 0;
  int nFail = 0;
  bit checkEn = 1'b0;

  // Model state: the valid sampled bits, oldest first.
  bit q[$];
  int mPat = 0, mLen = MAX_LEN, mZ = 0, mCnt = 0, mCnt2 = 0, mArmed = 0;
  bit mOvl = 1'b1;

  seq_recognizer_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .x(x), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .z(z), .match_count(match_count), .armed(armed)
  );

  seq_recognizer_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .x(x), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .z(z2), .match_count(match_count2), .armed(armed2)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a match means the last len sampled bits equal pat, newest bit at pat[0].
  always @(posedge clock) begin
    bit m;
    m = 1'b0;
    if (reset) begin
      q.delete();
      mPat = 0; mLen = MAX_LEN; mOvl = 1'b1; mCnt = 0; mCnt2 = 0;
    end else begin
      if (cfg_load) begin
        mPat = int'(cfg_pattern);
        mLen = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len));
        mOvl = cfg_overlap;
        q.delete();
      end else if (en) begin
        q.push_back(x);
        if (q.size() > MAX_LEN) void'(q.pop_front());
        if (q.size() >= mLen) begin
          m = 1'b1;
          for (int i = 0; i < mLen; i++) begin
            if (q[q.size()-1-i] != mPat[i]) m = 1'b0;
          end
        end
        if (m && !mOvl) q.delete();
      end
      if (m) begin
        if (mCnt < 255) mCnt++;
        if (mCnt2 < 3) mCnt2++;
      end
      if (count_clr) begin
        mCnt  = m ? 1 : 0;
        mCnt2 = m ? 1 : 0;
      end
    end
    mZ = m;
    mArmed = (q.size() >= mLen) ? 1 : 0;
  end

  always @(posedge clock) begin
    #2;
    if (checkEn) begin
      cmp("z", int'(z), mZ);
      cmp("match_count", int'(match_count), mCnt);
      cmp("armed", int'(armed), mArmed);
      cmp("z_cnt2", int'(z2), mZ);
      cmp("match_count_cnt2", int'(match_count2), mCnt2);
      cmp("armed_cnt2", int'(armed2), mArmed);
    end
  end

  task automatic applyStimulus(input logic enV, input logic xV, input logic ldV, input logic clrV);
    @(negedge clock);
    en = enV; x = xV; cfg_load = ldV; count_clr = clrV;
    @(posedge clock);
    #3;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    cmp(name, act, exp);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1; en = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b0;
  endtask

  task automatic loadCfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic feed(input logic b);
    applyStimulus(1'b1, b, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0] seq1 = 7'b1011011;
    logic [7:0] a5   = 8'hA5;

    doReset();
    checkEn = 1'b1;
    checkOutput("reset_z", int'(z), 0);
    checkOutput("reset_count", int'(match_count), 0);
    checkOutput("reset_armed", int'(armed), 0);

    // Overlapping 1011
    loadCfg(8'h0B, 4'd4, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      feed(seq1[i]);
      if (i == 3) checkOutput("t1_z4", int'(z), 1);
    end
    checkOutput("t1_z7", int'(z), 1);
    checkOutput("t1_count", int'(match_count), 2);

    // Non-overlapping 1011
    doReset();
    loadCfg(8'h0B, 4'd4, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      feed(seq1[i]);
      if (i == 3) begin
        checkOutput("t2_z4", int'(z), 1);
        checkOutput("t2_armed4", int'(armed), 0);
      end
    end
    checkOutput("t2_z7", int'(z), 0);
    checkOutput("t2_armed7", int'(armed), 0);
    feed(1'b0);
    checkOutput("t2_armed8", int'(armed), 1);
    checkOutput("t2_count", int'(match_count), 1);

    // en gaps with 110
    doReset();
    loadCfg(8'h06, 4'd3, 1'b1);
    feed(1'b1);
    feed(1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, logic'(i % 2), 1'b0, 1'b0);
      checkOutput("t3_gap_z", int'(z), 0);
    end
    feed(1'b0);
    checkOutput("t3_z", int'(z), 1);

    // Length 1, counter saturation on the 2-bit instance
    doReset();
    loadCfg(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      feed(1'b1);
      checkOutput("t4_cnt2", int'(match_count2), (i < 3) ? i + 1 : 3);
    end
    checkOutput("t4_cnt8", int'(match_count), 6);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t4_clr_cnt2", int'(match_count2), 1);
    checkOutput("t4_clr_cnt8", int'(match_count), 1);

    // Reset mid-sequence
    doReset();
    loadCfg(8'h0B, 4'd4, 1'b1);
    feed(1'b1); feed(1'b0); feed(1'b1);
    doReset();
    checkOutput("t5_rst_z", int'(z), 0);
    checkOutput("t5_rst_count", int'(match_count), 0);
    checkOutput("t5_rst_armed", int'(armed), 0);
    loadCfg(8'h0B, 4'd4, 1'b1);
    feed(1'b1);
    checkOutput("t5_z_first", int'(z), 0);
    feed(1'b1); feed(1'b0); feed(1'b1); feed(1'b1);
    checkOutput("t5_z", int'(z), 1);

    // Load drops the same-cycle sample; zero length becomes one
    doReset();
    cfg_pattern = 8'h01; cfg_len = 4'd0; cfg_overlap = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_load_z", int'(z), 0);
    checkOutput("t6_load_armed", int'(armed), 0);
    feed(1'b1);
    checkOutput("t6_z", int'(z), 1);

    // Oversize length clamps to MAX_LEN
    doReset();
    loadCfg(8'hA5, 4'd15, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      feed(a5[i]);
      if (i == 1) checkOutput("t7_armed7", int'(armed), 0);
    end
    checkOutput("t7_z", int'(z), 1);
    checkOutput("t7_armed", int'(armed), 1);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/seq_recognizer_param.md
# seq_recognizer_param

Parametrised serial sequence recognizer. It is the successor to the fixed-pattern single-bit recognizer. It compares an incoming bit stream against a runtime-loaded pattern of up to `MAX_LEN` bits and asserts a registered match pulse on `z`. It supports overlapping or non-overlapping detection and keeps a saturating count of matches. It sits between a serial front end (sampling `x` under `en`) and control logic that reads `z` and `match_count`.

## Interface
Parameters:
- `MAX_LEN`, default 8: maximum pattern length in bits, legal range 2..16.
- `CNT_W`, default 8: width of the match counter.

Ports:
- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: reset is synchronous and active-high.
- `x`, input, 1: serial data bit, sampled only when `en`=1.
- `en`, input, 1: sample strobe; when 0, all state holds (except config and counter clear).
- `cfg_load`, input, 1: load `cfg_pattern`, `cfg_len` and `cfg_overlap` into configuration registers.
- `cfg_pattern`, input, `MAX_LEN`: pattern. Bit 0 is the most recently received bit; bit `len-1` is the first received bit.
- `cfg_len`, input, `$clog2(MAX_LEN+1)`: pattern length. A value of 0 is stored as 1; values above `MAX_LEN` are stored as `MAX_LEN`.
- `cfg_overlap`, input, 1: 1 = overlapping detection, 0 = non-overlapping.
- `count_clr`, input, 1: clear `match_count`.
- `z`, output, 1: registered match pulse, one cycle wide per match.
- `match_count`, output, `CNT_W`: saturating number of matches.
- `armed`, output, 1: history holds at least `len` valid bits.

## Operation
- **State:**
  - `hist[MAX_LEN-1:0]`: shift register.
  - `fill`: 0..`MAX_LEN`, valid-bit count.
  - Config registers `pat`, `len`, `ovl`.
  - `match_count`.
  - `z` register.
- **Reset values:**
  - `hist`=0, `fill`=0, `z`=0, `match_count`=0.
  - `pat`=0, `len`=`MAX_LEN`, `ovl`=1.
  - `armed`=0.
- **Sample step** (`en`=1, `cfg_load`=0):
  - `hist_n` = {`hist[MAX_LEN-2:0]`, `x`}.
  - `fill_n` = min(`fill`+1, `MAX_LEN`).
  - `match` = (`fill_n` ≥ `len`) and (`hist_n[len-1:0]` == `pat[len-1:0]`). Higher bits are masked.
- **Update on sample step:**
  - `hist` ← `hist_n`.
  - `fill` ← 0 if `match` and `ovl`=0; otherwise `fill` ← `fill_n`.
- **`z`:** `z` ← `match` on sample steps; `z` ← 0 on every other cycle, including `en`=0 cycles.
- **Counter:**
  - On `match`, `match_count` increments, saturating at 2^`CNT_W`−1. It never wraps.
  - If `count_clr`=1: `match_count` ← (`match` ? 1 : 0).
- **`armed`:** combinational, (`fill` ≥ `len`).
- **Config load** (`cfg_load`=1):
  - Stores clamped config.
  - Clears `hist`, `fill` and `z`.
  - The same-cycle `x` sample is dropped, even if `en`=1.
  - `match_count` is untouched unless `count_clr`=1.
- **Priority:** `reset` > `cfg_load` > sample step. `count_clr` applies independently of `cfg_load`.

## Timing
- **Latency:** a match completed by the bit sampled at edge k is seen as `z`=1 after edge k, for exactly one cycle.
- **Counter timing:** `match_count` updates on the same edge as `z`.
- **Minimum match spacing:**
  - Overlapping: one sample step apart.
  - Non-overlapping: `len` sample steps apart.
- **Gaps in `en`:** do not break a sequence. Only sampled bits count.
- **Reset mid-sequence:** a reset mid-sequence discards partial history. The next match needs `len` fresh bits and the pattern must be reloaded, because reset clears it.
- **`cfg_len`=1:** every sampled bit equal to `pat[0]` produces `z`=1, in both modes.
- **`fill` saturation:** `fill` saturates at `MAX_LEN`; `armed` stays 1 afterwards in overlap mode.

## Test plan
1. Load pattern 1011 (`cfg_len`=4), `ovl`=1, `en`=1. Feed 1,0,1,1,0,1,1 → `z` pulses after the 4th and 7th samples; `match_count`=2.
2. Same stimulus with `ovl`=0 → `z` after the 4th sample only; `match_count`=1. After the 4th sample `armed`=0, and it stays 0 until 4 further bits have been sampled.
3. Pattern 110, `ovl`=1. Feed 1,1, then hold `en`=0 for 5 cycles with `x` toggling, then sample 0 → single `z` pulse on the first `en`=1 cycle after the gap; no `z` during the gap.
4. `CNT_W`=2, pattern 1 (`cfg_len`=1). Feed six 1s → `match_count` 1,2,3,3,3,3. Then pulse `count_clr` with `en`=1, `x`=1 → `match_count`=1.
5. Mid-sequence (1,0,1 of 1011): assert `reset` one cycle, reload, then feed 1 → no `z`. Then feed 1,0,1,1 → `z` after the 4th. All outputs read 0 the cycle after reset.
6. `cfg_load` asserted with `en`=1 and `x`=1, `cfg_len`=0, pattern bit0=1 → sample dropped, `z`=0, stored `len`=1. The next sampled 1 → `z`=1.
